// File: rtl/microwave_timer.sv
// microwave_timer: MM:SS BCD countdown with keypad entry, heating enable and done pulse
module microwave_timer #(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_closed,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       heating,
  output logic       done
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [15:0] t, t_n, t_dec;
  logic done_n, b0, b1, b2;
  assign {min_tens, min_ones, sec_tens, sec_ones} = t;
  // borrow chain; only the sec_tens reload uses 5, so entered values above 59 count down literally
  assign b0 = t[3:0] == 4'd0;
  assign b1 = b0 && t[7:4] == 4'd0;
  assign b2 = b1 && t[11:8] == 4'd0;
  assign t_dec = {b2 ? t[15:12] - 4'd1 : t[15:12],
                  b1 ? (t[11:8] == 4'd0 ? 4'd9 : t[11:8] - 4'd1) : t[11:8],
                  b0 ? (t[7:4] == 4'd0 ? 4'd5 : t[7:4] - 4'd1) : t[7:4],
                  b0 ? 4'd9 : t[3:0] - 4'd1};
  always_comb begin
    state_n = state;
    t_n = t;
    presc_n = presc;
    done_n = 1'b0;
    if (clear) begin
      state_n = IDLE;
      t_n = 16'h0000;
      presc_n = '0;
    end else if (stop || !door_closed) begin
      state_n = state == RUN ? PAUSE : state;
      presc_n = '0;
    end else if (state == RUN) begin
      presc_n = presc == LAST ? '0 : presc + 1'b1;
      t_n = presc == LAST ? t_dec : t;
      state_n = presc == LAST && t_dec == 16'h0000 ? IDLE : RUN;
      done_n = presc == LAST && t_dec == 16'h0000;
    end else if (start && t != 16'h0000) begin
      state_n = RUN;
      presc_n = '0;
    end else if (state == IDLE && digit_valid && digit <= 4'd9) begin
      t_n = {t[11:0], digit};
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      t <= 16'h0000;
      presc <= '0;
      heating <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      t <= t_n;
      presc <= presc_n;
      heating <= state_n == RUN;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_microwave_timer.sv
// tb_microwave_timer: directed vector table plus hand sequences for pause/resume and terminal-edge cases
module tb_microwave_timer;
  logic clk = 1'b0;
  logic reset, digit_valid, start, stop, clear, door_closed;
  logic [3:0] digit, min_tens, min_ones, sec_tens, sec_ones;
  logic heating, done;
  int checks = 0;
  int errors = 0;
  localparam logic [5:0] R = 6'b100000, DV = 6'b010000, ST = 6'b001000,
                         SP = 6'b000100, CL = 6'b000010, DR = 6'b000001;
  typedef struct {
    logic [5:0]  c;
    logic [3:0]  dg;
    logic [15:0] t;
    logic        h;
    logic        d;
  } vec_t;
  vec_t v[$];
  microwave_timer #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .digit(digit), .digit_valid(digit_valid),
    .start(start), .stop(stop), .clear(clear), .door_closed(door_closed),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .heating(heating), .done(done)
  );
  always #5 clk = ~clk;
  task automatic apply(input logic [5:0] c, input logic [3:0] dg);
    {reset, digit_valid, start, stop, clear, door_closed} = c;
    digit = dg;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [15:0] et, input logic eh, input logic ed);
    logic [17:0] got;
    got = {min_tens, min_ones, sec_tens, sec_ones, heating, done};
    checks++;
    if (got !== {et, eh, ed}) begin
      errors++;
      $display("FAIL %s: got time=%h heat=%b done=%b, expected time=%h heat=%b done=%b",
               n, got[17:2], got[1], got[0], et, eh, ed);
    end
  endtask
  task automatic push(input logic [5:0] c, input logic [3:0] dg, input logic [15:0] t,
                      input logic h, input logic d);
    v.push_back('{c: c, dg: dg, t: t, h: h, d: d});
  endtask
  initial begin
    {reset, digit_valid, start, stop, clear, door_closed} = R | DR;
    digit = 4'd0;
    push(R | DR, 4'd0, 16'h0000, 1'b0, 1'b0);
    push(DV | DR, 4'd1, 16'h0001, 1'b0, 1'b0);
    push(DV | DR, 4'd3, 16'h0013, 1'b0, 1'b0);
    push(DV | DR, 4'd0, 16'h0130, 1'b0, 1'b0);
    push(DV | DR, 4'd12, 16'h0130, 1'b0, 1'b0);
    push(CL | DR, 4'd0, 16'h0000, 1'b0, 1'b0);
    push(DV | DR, 4'd1, 16'h0001, 1'b0, 1'b0);
    push(ST | DR, 4'd0, 16'h0001, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) push(DR, 4'd0, 16'h0001, 1'b1, 1'b0);
    push(DR, 4'd0, 16'h0000, 1'b0, 1'b1);
    push(DR, 4'd0, 16'h0000, 1'b0, 1'b0);
    push(ST | DR, 4'd0, 16'h0000, 1'b0, 1'b0);
    push(DV | DR, 4'd1, 16'h0001, 1'b0, 1'b0);
    push(DV | DR, 4'd0, 16'h0010, 1'b0, 1'b0);
    push(DV | DR, 4'd0, 16'h0100, 1'b0, 1'b0);
    push(ST | DR, 4'd0, 16'h0100, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) push(DR, 4'd0, 16'h0100, 1'b1, 1'b0);
    push(DR, 4'd0, 16'h0059, 1'b1, 1'b0);
    push(CL | DR, 4'd0, 16'h0000, 1'b0, 1'b0);
    push(DV | DR, 4'd1, 16'h0001, 1'b0, 1'b0);
    push(DV | DR, 4'd0, 16'h0010, 1'b0, 1'b0);
    push(DV | DR, 4'd0, 16'h0100, 1'b0, 1'b0);
    push(DV | DR, 4'd0, 16'h1000, 1'b0, 1'b0);
    push(ST | DR, 4'd0, 16'h1000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) push(DR, 4'd0, 16'h1000, 1'b1, 1'b0);
    push(DR, 4'd0, 16'h0959, 1'b1, 1'b0);
    push(SP | DR, 4'd0, 16'h0959, 1'b0, 1'b0);
    push(DV | DR, 4'd5, 16'h0959, 1'b0, 1'b0);
    push(CL | DR, 4'd0, 16'h0000, 1'b0, 1'b0);
    push(DV | DR, 4'd9, 16'h0009, 1'b0, 1'b0);
    push(DV | DR, 4'd0, 16'h0090, 1'b0, 1'b0);
    push(ST, 4'd0, 16'h0090, 1'b0, 1'b0);
    push(ST | DR, 4'd0, 16'h0090, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) push(DR, 4'd0, 16'h0090, 1'b1, 1'b0);
    push(DR, 4'd0, 16'h0089, 1'b1, 1'b0);
    push(SP | ST | DR, 4'd0, 16'h0089, 1'b0, 1'b0);
    push(ST | DR, 4'd0, 16'h0089, 1'b1, 1'b0);
    push(DV | DR, 4'd7, 16'h0089, 1'b1, 1'b0);
    push(DR, 4'd0, 16'h0089, 1'b1, 1'b0);
    push(DR, 4'd0, 16'h0089, 1'b1, 1'b0);
    push(DR, 4'd0, 16'h0088, 1'b1, 1'b0);
    push(R | DR, 4'd0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < v.size(); i++) begin
      apply(v[i].c, v[i].dg);
      chk($sformatf("vec%0d", i), v[i].t, v[i].h, v[i].d);
    end
    // door opens mid-run at 00:04, resume decrements exactly 4 edges later
    apply(DV | DR, 4'd5);
    chk("key5", 16'h0005, 1'b0, 1'b0);
    apply(ST | DR, 4'd0);
    for (int i = 0; i < 3; i++) apply(DR, 4'd0);
    apply(DR, 4'd0);
    chk("tick_0004", 16'h0004, 1'b1, 1'b0);
    apply(DR, 4'd0);
    for (int i = 0; i < 10; i++) begin
      apply(6'b000000, 4'd0);
      chk($sformatf("door_open%0d", i), 16'h0004, 1'b0, 1'b0);
    end
    apply(ST | DR, 4'd0);
    chk("resume", 16'h0004, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply(DR, 4'd0);
      chk($sformatf("resume_hold%0d", i), 16'h0004, 1'b1, 1'b0);
    end
    apply(DR, 4'd0);
    chk("resume_tick", 16'h0003, 1'b1, 1'b0);
    apply(R | DR, 4'd0);
    chk("reset_mid_run", 16'h0000, 1'b0, 1'b0);
    apply(DR, 4'd0);
    chk("post_reset", 16'h0000, 1'b0, 1'b0);
    // stop on the terminal-tick edge wins: no decrement, no done
    apply(DV | DR, 4'd1);
    apply(ST | DR, 4'd0);
    for (int i = 0; i < 3; i++) apply(DR, 4'd0);
    apply(SP | DR, 4'd0);
    chk("stop_on_terminal", 16'h0001, 1'b0, 1'b0);
    apply(DR, 4'd0);
    chk("stop_no_done", 16'h0001, 1'b0, 1'b0);
    apply(ST | DR, 4'd0);
    for (int i = 0; i < 3; i++) apply(DR, 4'd0);
    apply(DR, 4'd0);
    chk("final_done", 16'h0000, 1'b0, 1'b1);
    apply(DR, 4'd0);
    chk("final_done_drop", 16'h0000, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
